// File: rtl/gate_array_bist.sv
// Gate-array datapath: per-lane 2-input gate selected by mode,
// PIPE output registers with valid/ready flow control, and a
// built-in self-test that drains the pipe, injects all 32
// mode/operand combinations and checks them against a truth table.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   mode, x, y      gate select and operands, taken with in_valid
//   in_valid        input beat offered
//   in_ready        input beat accepted this cycle
//   z, out_valid    registered result and its valid flag
//   out_ready       downstream accepts z
//   bist_start      request a self-test (honoured only when idle)
//   bist_busy       self-test in progress
//   bist_done       one-cycle pulse when the self-test ends
//   bist_pass       result of the last completed self-test

module gate_array_bist #(
   parameter int WIDTH = 8,
   parameter int PIPE  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] z,
   output logic             out_valid,
   input  logic             out_ready,
   input  logic             bist_start,
   output logic             bist_busy,
   output logic             bist_done,
   output logic             bist_pass
);

   typedef enum logic [2:0] {
      IDLE,
      DRAIN,
      RUN,
      CHECK,
      DONE
   } state_t;

   // Truth table indexed by {mode, x, y}; one nibble per mode,
   // mode 7 in the top nibble. Kept apart from the gate logic so
   // the self-test compares against an independent source.
   localparam logic [31:0] GOLD_TT = 32'hC396_1E87;

   state_t           st;
   logic [4:0]       cnt;
   logic             pass_run;

   logic [PIPE-1:0]  v;
   logic [PIPE-1:0]  tag;
   logic [WIDTH-1:0] d  [PIPE];
   logic [4:0]       vi [PIPE];

   logic             run;
   logic             adv;
   logic             ld_v;
   logic [2:0]       sel_mode;
   logic [WIDTH-1:0] sel_x;
   logic [WIDTH-1:0] sel_y;
   logic [WIDTH-1:0] fn_calc;
   wire  [WIDTH-1:0] fn_out;
   logic [WIDTH-1:0] golden;
   logic             mismatch;

   // Self-test results are consumed internally, so the pipe runs
   // freely during RUN/CHECK regardless of out_ready.
   always_comb begin
      run = (st == RUN);
      adv = 1'b1;
      if (st != RUN && st != CHECK)
         adv = !v[PIPE-1] || out_ready;
   end

   assign in_ready = !rst && (st == IDLE) && !bist_start && adv;

   always_comb begin
      ld_v = run;
      if (st == IDLE)
         ld_v = in_valid && in_ready;
   end

   always_comb begin
      sel_mode = mode;
      sel_x    = x;
      sel_y    = y;
      if (run) begin
         sel_mode = cnt[4:2];
         sel_x    = {WIDTH{cnt[1]}};
         sel_y    = {WIDTH{cnt[0]}};
      end
   end

   always_comb begin
      fn_calc = '0;
      unique case (sel_mode)
         3'd0: fn_calc = ~(sel_x & sel_y);
         3'd1: fn_calc = sel_x & sel_y;
         3'd2: fn_calc = sel_x | sel_y;
         3'd3: fn_calc = ~(sel_x | sel_y);
         3'd4: fn_calc = sel_x ^ sel_y;
         3'd5: fn_calc = ~(sel_x ^ sel_y);
         3'd6: fn_calc = ~sel_x;
         3'd7: fn_calc = sel_x;
      endcase
   end

   assign fn_out = fn_calc;

   always_comb begin
      golden   = {WIDTH{GOLD_TT[vi[PIPE-1]]}};
      mismatch = v[PIPE-1] && tag[PIPE-1]
                 && (d[PIPE-1] != golden);
   end

   // All stages move together; a stall anywhere freezes the pipe.
   always_ff @(posedge clk) begin
      if (rst) begin
         v   <= '0;
         tag <= '0;
         for (int i = 0; i < PIPE; i++) begin
            d[i]  <= '0;
            vi[i] <= '0;
         end
      end else if (adv) begin
         for (int i = PIPE - 1; i > 0; i--) begin
            v[i]   <= v[i-1];
            tag[i] <= tag[i-1];
            d[i]   <= d[i-1];
            vi[i]  <= vi[i-1];
         end
         v[0]   <= ld_v;
         tag[0] <= run;
         d[0]   <= fn_out;
         vi[0]  <= cnt;
      end
   end

   assign z         = d[PIPE-1];
   assign out_valid = v[PIPE-1] && !tag[PIPE-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         st        <= IDLE;
         cnt       <= '0;
         pass_run  <= 1'b0;
         bist_busy <= 1'b0;
         bist_done <= 1'b0;
         bist_pass <= 1'b0;
      end else begin
         bist_done <= 1'b0;
         unique case (st)
            IDLE: begin
               if (bist_start) begin
                  st        <= DRAIN;
                  bist_busy <= 1'b1;
               end
            end
            DRAIN: begin
               if (v == '0) begin
                  st       <= RUN;
                  cnt      <= '0;
                  pass_run <= 1'b1;
               end
            end
            RUN: begin
               if (mismatch)
                  pass_run <= 1'b0;
               cnt <= cnt + 5'd1;
               if (cnt == 5'd31) begin
                  st  <= CHECK;
                  cnt <= '0;
               end
            end
            CHECK: begin
               if (mismatch)
                  pass_run <= 1'b0;
               if (cnt == 5'(PIPE - 1)) begin
                  st        <= DONE;
                  bist_done <= 1'b1;
                  bist_pass <= pass_run && !mismatch;
               end else begin
                  cnt <= cnt + 5'd1;
               end
            end
            DONE: begin
               st        <= IDLE;
               bist_busy <= 1'b0;
            end
            default: begin
               st        <= IDLE;
               bist_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gate_array_bist.sv
// Bench for gate_array_bist: vector table, stall/BIST sequences
// and a queue-based scoreboard under random traffic.

module tb_gate_array_bist;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] mode = '0;
   logic [7:0] x = '0;
   logic [7:0] y = '0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b1;
   logic       bist_start = 1'b0;

   logic       ir1, ov1, bb1, bd1, bp1;
   logic [7:0] z1;
   logic       ir3, ov3, bb3, bd3, bp3;
   logic [7:0] z3;

   int nvec = 0;
   int nerr = 0;
   logic [7:0] fv;

   always #5 clk = ~clk;

   gate_array_bist #(.WIDTH(8), .PIPE(1)) dut1 (
      .clk(clk), .rst(rst), .mode(mode), .x(x), .y(y),
      .in_valid(in_valid), .in_ready(ir1), .z(z1),
      .out_valid(ov1), .out_ready(out_ready),
      .bist_start(bist_start), .bist_busy(bb1),
      .bist_done(bd1), .bist_pass(bp1)
   );

   gate_array_bist #(.WIDTH(8), .PIPE(3)) dut3 (
      .clk(clk), .rst(rst), .mode(mode), .x(x), .y(y),
      .in_valid(in_valid), .in_ready(ir3), .z(z3),
      .out_valid(ov3), .out_ready(out_ready),
      .bist_start(bist_start), .bist_busy(bb3),
      .bist_done(bd3), .bist_pass(bp3)
   );

   typedef struct {
      logic [2:0] m;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] e;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h want %0h", nm, got, exp);
      end
   endtask

   function automatic logic [7:0] ref_fn(input logic [2:0] m,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
      logic [7:0] r;
      r = '0;
      for (int l = 0; l < 8; l++) begin
         case (m)
            3'd0: r[l] = !(a[l] && b[l]);
            3'd1: r[l] = a[l] && b[l];
            3'd2: r[l] = a[l] || b[l];
            3'd3: r[l] = !(a[l] || b[l]);
            3'd4: r[l] = a[l] != b[l];
            3'd5: r[l] = a[l] == b[l];
            3'd6: r[l] = !a[l];
            default: r[l] = a[l];
         endcase
      end
      return r;
   endfunction

   // Starts a self-test on the current negedge and follows it to
   // the end. With fault set, lane 5 of the mode-3 vectors is
   // corrupted at the gate output of the PIPE=3 instance.
   task automatic bist_run(input bit fault, output int nbusy,
                           output int ndone, output logic pass_d,
                           output logic pass_pre,
                           output logic ov_seen);
      nbusy = 0;
      ndone = 0;
      pass_d = 1'b0;
      pass_pre = 1'b0;
      ov_seen = 1'b0;
      bist_start = 1'b1;
      in_valid = 1'b1;
      mode = 3'd0;
      x = 8'h00;
      y = 8'h00;
      #1 chk("start_in_ready", ir3, 0);
      @(negedge clk);
      bist_start = 1'b0;
      in_valid = 1'b0;
      for (int c = 0; c < 80; c++) begin
         // cycle c=k+1 injects vector k; mode 3 is vectors 12..15
         if (fault && c >= 13 && c <= 16) begin
            fv = (c == 13) ? 8'hDF : 8'h20;
            force dut3.fn_out = fv;
         end else begin
            release dut3.fn_out;
         end
         #1;
         if (c == 0) pass_pre = bp3;
         if (ov3) ov_seen = 1'b1;
         if (bd3) begin
            ndone++;
            pass_d = bp3;
         end
         if (!bb3) begin
            @(negedge clk);
            break;
         end
         nbusy++;
         @(negedge clk);
      end
      release dut3.fn_out;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[12];
      logic [7:0] q[$];
      int acc, taken, nbusy, ndone, cnt;
      logic pass_d, pass_pre, ov_seen, prev_stall;
      logic [7:0] prev_z, e;
      bit seen_bad;

      tbl[0]  = '{3'd0, 8'h00, 8'h00, 8'hFF};
      tbl[1]  = '{3'd0, 8'h00, 8'hFF, 8'hFF};
      tbl[2]  = '{3'd0, 8'hFF, 8'h00, 8'hFF};
      tbl[3]  = '{3'd0, 8'hFF, 8'hFF, 8'h00};
      tbl[4]  = '{3'd0, 8'hA5, 8'h3C, 8'hDB};
      tbl[5]  = '{3'd1, 8'hA5, 8'h3C, 8'h24};
      tbl[6]  = '{3'd2, 8'hA5, 8'h3C, 8'hBD};
      tbl[7]  = '{3'd3, 8'hA5, 8'h3C, 8'h42};
      tbl[8]  = '{3'd4, 8'hA5, 8'h3C, 8'h99};
      tbl[9]  = '{3'd5, 8'hA5, 8'h3C, 8'h66};
      tbl[10] = '{3'd6, 8'hA5, 8'h3C, 8'h5A};
      tbl[11] = '{3'd7, 8'hA5, 8'h3C, 8'hA5};

      // reset state
      repeat (3) @(negedge clk);
      #1;
      chk("rst_in_ready1", ir1, 0);
      chk("rst_in_ready3", ir3, 0);
      chk("rst_out_valid", ov3, 0);
      chk("rst_z", z3, 0);
      chk("rst_busy", bb3, 0);
      chk("rst_done", bd3, 0);
      chk("rst_pass", bp3, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_rst_ready1", ir1, 1);
      chk("post_rst_ready3", ir3, 1);
      @(negedge clk);

      // vector table, back-to-back, out_ready=1
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         in_valid = 1'b1;
         mode = tbl[i].m;
         x = tbl[i].a;
         y = tbl[i].b;
         #1;
         chk("tbl_in_ready", ir1, 1);
         if (i > 0) begin
            chk("tbl_ov_p1", ov1, 1);
            chk("tbl_z_p1", z1, tbl[i-1].e);
         end
         if (i >= 3) chk("tbl_z_p3", z3, tbl[i-3].e);
         @(negedge clk);
      end
      in_valid = 1'b0;
      #1;
      chk("tbl_z_p1_last", z1, tbl[11].e);
      repeat (6) @(negedge clk);

      // stall with PIPE=3
      out_ready = 1'b0;
      in_valid = 1'b1;
      mode = 3'd4;
      x = 8'hA5;
      y = 8'h3C;
      acc = 0;
      for (int c = 0; c < 8; c++) begin
         #1;
         if (ir3) acc++;
         if (c >= 3) begin
            chk("stall_ov", ov3, 1);
            chk("stall_z", z3, 8'h99);
            chk("stall_ready", ir3, 0);
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      taken = 0;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (ov3) begin
            taken++;
            chk("stall_drain_z", z3, 8'h99);
         end
         @(negedge clk);
      end
      chk("stall_accepted", acc, 3);
      chk("stall_taken", taken, 3);

      // clean BIST, pipe empty
      bist_run(0, nbusy, ndone, pass_d, pass_pre, ov_seen);
      chk("bist_busy_len", nbusy, 37);
      chk("bist_done_cnt", ndone, 1);
      chk("bist_pass", pass_d, 1);
      chk("bist_ov", ov_seen, 0);

      // faulty BIST then clean BIST
      bist_run(1, nbusy, ndone, pass_d, pass_pre, ov_seen);
      chk("fault_busy_len", nbusy, 37);
      chk("fault_pass", pass_d, 0);
      bist_run(0, nbusy, ndone, pass_d, pass_pre, ov_seen);
      chk("hold_pass_prev", pass_pre, 0);
      chk("clean_pass", pass_d, 1);
      chk("clean_done_cnt", ndone, 1);

      // BIST requested with a stalled result
      out_ready = 1'b0;
      in_valid = 1'b1;
      mode = 3'd7;
      x = 8'h5A;
      y = 8'h00;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("drain_pre_ov", ov3, 1);
      chk("drain_pre_z", z3, 8'h5A);
      bist_start = 1'b1;
      @(negedge clk);
      bist_start = 1'b0;
      for (int c = 0; c < 4; c++) begin
         #1;
         chk("drain_busy", bb3, 1);
         chk("drain_ov", ov3, 1);
         chk("drain_z", z3, 8'h5A);
         @(negedge clk);
      end
      out_ready = 1'b1;
      cnt = 0;
      ndone = 0;
      pass_d = 1'b0;
      for (int c = 0; c < 80; c++) begin
         #1;
         if (bd3) begin
            ndone++;
            pass_d = bp3;
         end
         if (!bb3) begin
            @(negedge clk);
            break;
         end
         cnt++;
         @(negedge clk);
      end
      chk("drain_rest_len", cnt, 38);
      chk("drain_done_cnt", ndone, 1);
      chk("drain_pass", pass_d, 1);

      // reset in the middle of RUN
      bist_start = 1'b1;
      @(negedge clk);
      bist_start = 1'b0;
      repeat (11) @(negedge clk);
      #1;
      chk("abort_busy_pre", bb3, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("abort_busy", bb3, 0);
      chk("abort_ov", ov3, 0);
      chk("abort_pass", bp3, 0);
      chk("abort_ready", ir3, 1);
      seen_bad = 0;
      for (int c = 0; c < 40; c++) begin
         if (bd3 || ov3 || bb3) seen_bad = 1;
         @(negedge clk);
         #1;
      end
      chk("abort_residual", seen_bad, 0);
      @(negedge clk);

      // random traffic against a queue model
      prev_stall = 1'b0;
      prev_z = '0;
      for (int c = 0; c < 400; c++) begin
         in_valid = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         mode = 3'($urandom);
         x = 8'($urandom);
         y = 8'($urandom);
         #1;
         chk("rnd_in_ready", ir3, !ov3 || out_ready);
         if (prev_stall) begin
            chk("rnd_hold_ov", ov3, 1);
            chk("rnd_hold_z", z3, prev_z);
         end
         if (ov3 && out_ready) begin
            if (q.size() == 0) begin
               nvec++;
               nerr++;
               $display("FAIL rnd_extra: got %0h want none", z3);
            end else begin
               e = q.pop_front();
               chk("rnd_z", z3, e);
            end
         end
         if (in_valid && ir3) q.push_back(ref_fn(mode, x, y));
         prev_stall = ov3 && !out_ready;
         prev_z = z3;
         @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (ov3) begin
            if (q.size() == 0) begin
               nvec++;
               nerr++;
               $display("FAIL rnd_extra: got %0h want none", z3);
            end else begin
               e = q.pop_front();
               chk("rnd_tail_z", z3, e);
            end
         end
         @(negedge clk);
      end
      chk("rnd_lost", q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               nvec, nerr);
      $finish;
   end

endmodule
